// File: rtl/c2s_responder_if.sv
// Request/response streams to the C bridge and the local handler call port of c2s_responder.
// slave = responder side, master = bridge/handler side.
interface c2s_responder_if #(
   parameter int DATA_SIZE = 4,
   parameter int NUM_ID    = 16
);
   localparam int ID_W = $clog2(NUM_ID);

   logic                    req_valid;
   logic                    req_ready;
   logic [31:0]             req_data;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [31:0]             rsp_data;
   logic                    hdl_req;
   logic [ID_W-1:0]         hdl_id;
   logic [32*DATA_SIZE-1:0] hdl_data;
   logic                    hdl_ack;
   logic [31:0]             hdl_ret;
   logic [32*DATA_SIZE-1:0] hdl_rdata;

   modport slave (
      input  req_valid, req_data, rsp_ready, hdl_ack, hdl_ret, hdl_rdata,
      output req_ready, rsp_valid, rsp_data, hdl_req, hdl_id, hdl_data
   );

   modport master (
      output req_valid, req_data, rsp_ready, hdl_ack, hdl_ret, hdl_rdata,
      input  req_ready, rsp_valid, rsp_data, hdl_req, hdl_id, hdl_data
   );
endinterface

// File: rtl/c2s_responder.sv
// Sim-side responder for C-initiated calls: frame RX, decode, handler call, response TX.
// Optional handler-ack watchdog enabled by defining C2S_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RX   | accepting request words id, fn, payload[0..DATA_SIZE-1]
// ST_EXEC | one-cycle decode of id/fn, table update, ret selection
// ST_CALL | hdl_req held until hdl_ack (or watchdog expiry)
// ST_TX   | sending ret then data[0..DATA_SIZE-1]
module c2s_responder #(
   parameter int DATA_SIZE   = 4,
   parameter int NUM_ID      = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   c2s_responder_if.slave  bus,
   input  logic            end_req,
   output logic            busy
);
   localparam int ID_W  = $clog2(NUM_ID);
   localparam int CNT_W = $clog2(DATA_SIZE + 2);
   localparam int K_W   = $clog2(DATA_SIZE + 1);
   localparam logic [CNT_W-1:0] LAST_REQ = CNT_W'(DATA_SIZE + 1);
   localparam logic [K_W-1:0]   LAST_RSP = K_W'(DATA_SIZE);

   typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_CALL, ST_TX} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [K_W-1:0]    tx_k;
   logic [31:0]       id_q, fn_q, ret_q;
   logic [31:0]       pay_q  [DATA_SIZE];
   logic [31:0]       rdat_q [DATA_SIZE];
   logic [NUM_ID-1:0] reg_tbl;
   logic              id_bad, id_reg, call_go, tmo_hit;
   logic [31:0]       exec_ret;

   assign id_bad = (id_q >= 32'(NUM_ID));
   assign id_reg = reg_tbl[id_q[ID_W-1:0]];
   assign busy   = (state != ST_RX) || (cnt != '0);

   // Decode priority: bad id, then fn (setup / call / check_end / unknown).
   always_comb begin
      exec_ret = 32'h0;
      call_go  = 1'b0;
      if (id_bad) begin
         exec_ret = 32'hFFFF_FFFF;
      end else begin
         case (fn_q)
            32'd0:   exec_ret = 32'h0;
            32'd1:   if (id_reg) call_go = 1'b1;
                     else        exec_ret = 32'hFFFF_FFFE;
            32'd2:   exec_ret = {31'h0, end_req};
            default: exec_ret = 32'hFFFF_FFFD;
         endcase
      end
   end

`ifdef C2S_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Held at zero outside CALL so every call starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                tmo_cnt <= '0;
      else if (state != ST_CALL) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (state == ST_CALL) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RX;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.hdl_req   = 1'b0;
      case (state)
         ST_RX: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid && (cnt == LAST_REQ)) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = call_go ? ST_CALL : ST_TX;
         ST_CALL: begin
            bus.hdl_req = 1'b1;
            if (bus.hdl_ack || tmo_hit) state_nxt = ST_TX;
         end
         ST_TX: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready && (tx_k == LAST_RSP)) state_nxt = ST_RX;
         end
         default: state_nxt = ST_RX;
      endcase
   end

   always_comb begin
      bus.rsp_data = 32'h0;
      bus.hdl_id   = '0;
      bus.hdl_data = '0;
      if (state == ST_TX) begin
         bus.rsp_data = ret_q;
         for (int i = 0; i < DATA_SIZE; i++)
            if (tx_k == K_W'(i + 1)) bus.rsp_data = rdat_q[i];
      end
      if (state == ST_CALL) begin
         bus.hdl_id = id_q[ID_W-1:0];
         for (int i = 0; i < DATA_SIZE; i++)
            bus.hdl_data[32*i +: 32] = pay_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         tx_k    <= '0;
         id_q    <= 32'h0;
         fn_q    <= 32'h0;
         ret_q   <= 32'h0;
         reg_tbl <= '0;
         for (int i = 0; i < DATA_SIZE; i++) begin
            pay_q[i]  <= 32'h0;
            rdat_q[i] <= 32'h0;
         end
      end else begin
         case (state)
            ST_RX: if (bus.req_valid) begin
               if (cnt == CNT_W'(0)) id_q <= bus.req_data;
               if (cnt == CNT_W'(1)) fn_q <= bus.req_data;
               for (int i = 0; i < DATA_SIZE; i++)
                  if (cnt == CNT_W'(i + 2)) pay_q[i] <= bus.req_data;
               cnt <= (cnt == LAST_REQ) ? '0 : cnt + 1'b1;
            end
            ST_EXEC: begin
               ret_q <= exec_ret;
               tx_k  <= '0;
               for (int i = 0; i < DATA_SIZE; i++) rdat_q[i] <= 32'h0;
               if (!id_bad && (fn_q == 32'd0)) reg_tbl[id_q[ID_W-1:0]] <= 1'b1;
            end
            ST_CALL: begin
               // A same-cycle ack beats watchdog expiry.
               if (bus.hdl_ack) begin
                  ret_q <= bus.hdl_ret;
                  for (int i = 0; i < DATA_SIZE; i++)
                     rdat_q[i] <= bus.hdl_rdata[32*i +: 32];
               end else if (tmo_hit) begin
                  ret_q <= 32'hFFFF_FFFC;
               end
            end
            ST_TX: if (bus.rsp_ready) tx_k <= (tx_k == LAST_RSP) ? '0 : tx_k + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_c2s_responder.sv
// Self-checking bench for c2s_responder: directed vector table, hand sequences, random frames vs model.
module tb_c2s_responder;
   localparam int DS   = 4;
   localparam int NID  = 16;
   localparam int IDW  = $clog2(NID);
`ifdef C2S_TIMEOUT_EN
   localparam int TMO  = 8;
`else
   localparam int TMO  = 1024;
`endif

   typedef logic [31:0] word_t;

   typedef struct {
      word_t id;
      word_t fn;
      bit    endr;
      int    dly;
      word_t hret;
      bit    tog;
      int    stall;
      word_t exp_ret;
      bit    exp_call;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic end_req = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   c2s_responder_if #(.DATA_SIZE(DS), .NUM_ID(NID)) bus ();

   c2s_responder #(.DATA_SIZE(DS), .NUM_ID(NID), .TIMEOUT_CYC(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .end_req (end_req),
      .busy    (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit mtab [NID];

   task automatic chk(input string name, input word_t act, input word_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference: spec rules applied to a whole frame; updates the registration table.
   task automatic model(input word_t id, input word_t fn, input bit endr, input int dly,
                        input word_t hret, input word_t hrd[DS],
                        output word_t exp[DS+1], output bit call);
      bit tmo_exp = 1'b0;
`ifdef C2S_TIMEOUT_EN
      tmo_exp = (dly >= TMO);
`endif
      for (int k = 0; k <= DS; k++) exp[k] = 32'h0;
      call = 1'b0;
      if (id >= NID)     exp[0] = 32'hFFFF_FFFF;
      else if (fn == 0)  begin mtab[id[IDW-1:0]] = 1'b1; exp[0] = 32'h0; end
      else if (fn == 1)  begin
         if (!mtab[id[IDW-1:0]]) exp[0] = 32'hFFFF_FFFE;
         else begin
            call = 1'b1;
            if (tmo_exp) exp[0] = 32'hFFFF_FFFC;
            else begin
               exp[0] = hret;
               for (int k = 0; k < DS; k++) exp[k+1] = hrd[k];
            end
         end
      end
      else if (fn == 2)  exp[0] = {31'h0, endr};
      else               exp[0] = 32'hFFFF_FFFD;
   endtask

   task automatic do_frame(input word_t id, input word_t fn, input word_t pay[DS], input bit endr,
                           input int dly, input word_t hret, input word_t hrd[DS], input bit tog,
                           input int stall, input word_t exp[DS+1], input bit call, input string tag);
      word_t words [DS+2];
      int    guard;
      end_req = endr;
      words[0] = id;
      words[1] = fn;
      for (int k = 0; k < DS; k++) words[k+2] = pay[k];
      for (int w = 0; w < DS + 2; w++) begin
         if (tog) begin @(negedge clk); bus.req_valid = 1'b0; end
         @(negedge clk);
         bus.req_valid = 1'b1;
         bus.req_data  = words[w];
         guard = 0;
         while (!bus.req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
               chk({tag, ".req_ready_wait"}, 32'(bus.req_ready), 32'h1);
               bus.req_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_data  = $urandom;
      chk({tag, ".exec_req_ready"}, 32'(bus.req_ready), 32'h0);
      chk({tag, ".exec_busy"}, 32'(busy), 32'h1);
      chk({tag, ".exec_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      chk({tag, ".hdl_req"}, 32'(bus.hdl_req), 32'(call));
      if (call) begin
         chk({tag, ".hdl_id"}, 32'(bus.hdl_id), 32'(id[IDW-1:0]));
         for (int k = 0; k < DS; k++)
            chk($sformatf("%s.hdl_data%0d", tag, k), bus.hdl_data[32*k +: 32], pay[k]);
         if (dly >= TMO) begin
            for (int c = 1; c < TMO; c++) begin
               @(negedge clk);
               chk({tag, ".tmo_hdl_req_held"}, 32'(bus.hdl_req), 32'h1);
            end
            @(negedge clk);
            chk({tag, ".tmo_hdl_req_drop"}, 32'(bus.hdl_req), 32'h0);
         end else begin
            for (int c = 0; c < dly; c++) begin
               @(negedge clk);
               chk({tag, ".hdl_req_held"}, 32'(bus.hdl_req), 32'h1);
               chk({tag, ".hdl_data_stable"}, bus.hdl_data[31:0], pay[0]);
            end
            bus.hdl_ack = 1'b1;
            bus.hdl_ret = hret;
            for (int k = 0; k < DS; k++) bus.hdl_rdata[32*k +: 32] = hrd[k];
            @(negedge clk);
            bus.hdl_ack   = 1'b0;
            bus.hdl_ret   = $urandom;
            bus.hdl_rdata = {$urandom, $urandom, $urandom, $urandom};
            chk({tag, ".hdl_req_drop"}, 32'(bus.hdl_req), 32'h0);
         end
      end
      for (int k = 0; k <= DS; k++) begin
         chk($sformatf("%s.rsp_valid%0d", tag, k), 32'(bus.rsp_valid), 32'h1);
         chk($sformatf("%s.rsp_word%0d", tag, k), bus.rsp_data, exp[k]);
         chk({tag, ".tx_req_ready"}, 32'(bus.req_ready), 32'h0);
         bus.req_valid = tog;
         bus.req_data  = $urandom;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk($sformatf("%s.stall_word%0d", tag, k), bus.rsp_data, exp[k]);
         end
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end
      bus.req_valid = 1'b0;
      chk({tag, ".end_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
      chk({tag, ".end_rsp_data"}, bus.rsp_data, 32'h0);
      chk({tag, ".end_busy"}, 32'(busy), 32'h0);
      chk({tag, ".end_req_ready"}, 32'(bus.req_ready), 32'h1);
   endtask

   // Model-driven frame: expectations come from the reference model.
   task automatic run_model(input word_t id, input word_t fn, input word_t pay[DS], input bit endr,
                            input int dly, input word_t hret, input word_t hrd[DS], input bit tog,
                            input int stall, input string tag);
      word_t exp [DS+1];
      bit    call;
      model(id, fn, endr, dly, hret, hrd, exp, call);
      do_frame(id, fn, pay, endr, dly, hret, hrd, tog, stall, exp, call, tag);
   endtask

   vec_t  vecs [14];
   word_t pay  [DS];
   word_t hrd  [DS];
   word_t exp  [DS+1];
   word_t dexp [DS+1];
   bit    dcall;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_data  = 32'h0;
      bus.rsp_ready = 1'b0;
      bus.hdl_ack   = 1'b0;
      bus.hdl_ret   = 32'h0;
      bus.hdl_rdata = '0;

      //            id      fn  endr dly hret          tog stall exp_ret        call
      vecs[0]  = '{32'd3,  0,  0, 0, 32'h0,        0, 0, 32'h0,         0};
      vecs[1]  = '{32'd3,  1,  0, 2, 32'h7,        0, 0, 32'h7,         1};
      vecs[2]  = '{32'd5,  1,  0, 0, 32'h0,        0, 0, 32'hFFFF_FFFE, 0};
      vecs[3]  = '{32'd16, 1,  0, 0, 32'h0,        0, 0, 32'hFFFF_FFFF, 0};
      vecs[4]  = '{32'd3,  9,  0, 0, 32'h0,        0, 0, 32'hFFFF_FFFD, 0};
      vecs[5]  = '{32'd3,  2,  0, 0, 32'h0,        0, 0, 32'h0,         0};
      vecs[6]  = '{32'd3,  2,  1, 0, 32'h0,        0, 0, 32'h1,         0};
      vecs[7]  = '{32'd3,  0,  0, 0, 32'h0,        0, 0, 32'h0,         0};
      vecs[8]  = '{32'd7,  0,  0, 0, 32'h0,        1, 5, 32'h0,         0};
      vecs[9]  = '{32'd7,  1,  0, 3, 32'h1234,     1, 5, 32'h1234,      1};
      vecs[10] = '{32'h100,0,  0, 0, 32'h0,        0, 0, 32'hFFFF_FFFF, 0};
      vecs[11] = '{32'd15, 0,  0, 0, 32'h0,        0, 1, 32'h0,         0};
      vecs[12] = '{32'd15, 1,  1, 0, 32'hDEAD,     0, 2, 32'hDEAD,      1};
      vecs[13] = '{32'd2,  3,  1, 0, 32'h0,        1, 0, 32'hFFFF_FFFD, 0};

      repeat (2) @(negedge clk);
      chk("rst.req_ready", 32'(bus.req_ready), 32'h1);
      chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst.rsp_data", bus.rsp_data, 32'h0);
      chk("rst.hdl_req", 32'(bus.hdl_req), 32'h0);
      chk("rst.hdl_id", 32'(bus.hdl_id), 32'h0);
      for (int k = 0; k < DS; k++) chk("rst.hdl_data", bus.hdl_data[32*k +: 32], 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      for (int k = 0; k < DS; k++) begin pay[k] = 32'(k + 1); hrd[k] = 32'hA + 32'(k); end
      for (int v = 0; v < 14; v++) begin
         for (int k = 0; k <= DS; k++) exp[k] = 32'h0;
         exp[0] = vecs[v].exp_ret;
         if (vecs[v].exp_call) for (int k = 0; k < DS; k++) exp[k+1] = hrd[k];
         model(vecs[v].id, vecs[v].fn, vecs[v].endr, vecs[v].dly, vecs[v].hret, hrd, dexp, dcall);
         do_frame(vecs[v].id, vecs[v].fn, pay, vecs[v].endr, vecs[v].dly, vecs[v].hret, hrd,
                  vecs[v].tog, vecs[v].stall, exp, vecs[v].exp_call, $sformatf("vec%0d", v));
      end

      // hdl_ack while no call is pending must be ignored.
      bus.hdl_ack = 1'b1;
      bus.hdl_ret = 32'h55;
      repeat (3) @(negedge clk);
      chk("idle_ack.hdl_req", 32'(bus.hdl_req), 32'h0);
      run_model(32'd3, 32'd2, pay, 1'b1, 0, 32'h0, hrd, 1'b0, 0, "idle_ack");
      bus.hdl_ack = 1'b0;

      // Reset after three request words of a call to registered id 7.
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         bus.req_valid = 1'b1;
         bus.req_data  = (w == 0) ? 32'd7 : (w == 1) ? 32'd1 : 32'h99;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("midrst.busy_before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst.busy", 32'(busy), 32'h0);
      chk("midrst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("midrst.req_ready", 32'(bus.req_ready), 32'h1);
      rst_n = 1'b1;
      for (int i = 0; i < NID; i++) mtab[i] = 1'b0;
      run_model(32'd9, 32'd0, pay, 1'b0, 0, 32'h0, hrd, 1'b0, 0, "midrst.setup");
      repeat (4) @(negedge clk);
      chk("midrst.no_extra_rsp", 32'(bus.rsp_valid), 32'h0);
      run_model(32'd7, 32'd1, pay, 1'b0, 0, 32'h0, hrd, 1'b0, 0, "midrst.stale_call");

`ifdef C2S_TIMEOUT_EN
      run_model(32'd4, 32'd0, pay, 1'b0, 0, 32'h0, hrd, 1'b0, 0, "tmo.setup");
      run_model(32'd4, 32'd1, pay, 1'b0, 100, 32'h0, hrd, 1'b0, 0, "tmo.noack");
      run_model(32'd4, 32'd1, pay, 1'b0, TMO - 1, 32'h77, hrd, 1'b0, 1, "tmo.lastack");
`endif

      for (int n = 0; n < 40; n++) begin
         word_t id, fn, hret;
         int    r, dly;
         id = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
         r  = $urandom_range(0, 9);
         fn = (r < 4) ? 32'd1 : (r < 6) ? 32'd0 : (r < 8) ? 32'd2 : 32'($urandom_range(3, 40));
`ifdef C2S_TIMEOUT_EN
         dly = $urandom_range(0, 11);
`else
         dly = $urandom_range(0, 4);
`endif
         hret = $urandom;
         for (int k = 0; k < DS; k++) begin pay[k] = $urandom; hrd[k] = $urandom; end
         run_model(id, fn, pay, 1'($urandom_range(0, 1)), dly, hret, hrd,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
